// File: rtl/requant_axi_fetch_pkg.sv
// Shared definitions for the requantizer AXI fetch master: AXI encodings,
// 4KB boundary geometry, FSM state encoding and burst-length bounds.
package requant_axi_fetch_pkg;

    localparam logic [1:0] ABURST_INCR   = 2'b01;
    localparam logic [2:0] ASIZE_4B      = 3'b010;
    localparam logic [1:0] RESP_OKAY     = 2'b00;

    localparam int BOUNDARY_4KB  = 4096;
    localparam int WORDS_PER_4KB = BOUNDARY_4KB / 4;
    localparam int AXI_MAX_BURST = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_FLUSH = 3'd4
    } fetch_state_t;

    // AXI4 INCR bursts carry 1..256 beats.
    function automatic bit burst_len_ok(input int len);
        return (len >= 1) && (len <= AXI_MAX_BURST);
    endfunction

    // Usable burst cap: an out-of-range setting is pulled back into 1..256.
    function automatic int burst_cap(input int len);
        if (burst_len_ok(len)) return len;
        if (len < 1)           return 1;
        return AXI_MAX_BURST;
    endfunction

endpackage

// File: rtl/requant_axi_burst_calc.sv
// Combinational burst sizer: beats = min(remaining, MAX_BURST_LEN, words left
// before the next 4KB boundary). Result is always 1..256 when remaining > 0.
module requant_axi_burst_calc
    import requant_axi_fetch_pkg::*;
#(
    parameter int BW_INDEX      = 13,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [BW_INDEX-1:0] remaining,
    input  logic [9:0]          word_offset,
    output logic [8:0]          beats
);

    localparam int CAP = burst_cap(MAX_BURST_LEN);

    logic [31:0] rem_w;
    logic [31:0] bnd_w;
    logic [31:0] pick;

    // Three-way minimum on 32-bit operands so no width can overflow.
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        rem_w = 32'(remaining);
        bnd_w = 32'(WORDS_PER_4KB) - 32'(word_offset);
        pick  = rem_w;
        if (32'(CAP) < pick) pick = 32'(CAP);
        if (bnd_w < pick)    pick = bnd_w;
        beats = 9'(pick);
    end

endmodule

// File: rtl/requant_axi_fetch_master.sv
// AXI4 read initiator that bulk-loads requantizer input words from external
// memory into a local buffer write port. One burst outstanding at a time,
// bursts never cross a 4KB boundary.
// Optional busy-cycle counter: define REQUANT_AXI_FETCH_PERF_EN.
module requant_axi_fetch_master
    import requant_axi_fetch_pkg::*;
#(
    parameter int BW_ADDR       = 32,
    parameter int BW_DATA       = 32,
    parameter int BW_AXI_TID    = 4,
    parameter int AXI_TID       = 0,
    parameter int BW_INDEX      = 13,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rstnn,
    input  logic                  start,
    input  logic [BW_ADDR-1:0]    src_addr,
    input  logic [BW_INDEX-1:0]   num_words,
    input  logic [BW_INDEX-1:0]   dst_index,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [BW_AXI_TID-1:0] sxarid,
    output logic [BW_ADDR-1:0]    sxaraddr,
    output logic [7:0]            sxarlen,
    output logic [2:0]            sxarsize,
    output logic [1:0]            sxarburst,
    output logic                  sxarvalid,
    input  logic                  sxarready,
    input  logic [BW_AXI_TID-1:0] sxrid,
    input  logic [BW_DATA-1:0]    sxrdata,
    input  logic [1:0]            sxrresp,
    input  logic                  sxrlast,
    input  logic                  sxrvalid,
    output logic                  sxrready,
    output logic [BW_INDEX-1:0]   windex,
    output logic                  wenable,
    output logic [BW_DATA/8-1:0]  wpermit,
    output logic [BW_DATA-1:0]    wdata,
    output logic [31:0]           perf_cycles
);

    localparam int BW_STRB = BW_DATA / 8;

    fetch_state_t        state;
    logic [BW_ADDR-1:0]  addr_q;
    logic [BW_INDEX-1:0] remaining_q;
    logic [BW_INDEX-1:0] wptr_q;
    logic [8:0]          beats_q;
    logic [8:0]          beat_cnt_q;
    logic                draining_q;

    logic [8:0]          calc_beats;
    logic                start_accept;
    logic                beat_fire;
    logic                beat_is_last;
    logic [BW_ADDR-1:0]  addr_step;
    logic [BW_INDEX-1:0] remaining_after;
    logic                unused_ok;

    // Read ID is not needed: only one burst is ever in flight.
    assign unused_ok = ^sxrid;

    assign sxarid    = BW_AXI_TID'(AXI_TID);
    assign sxarsize  = ASIZE_4B;
    assign sxarburst = ABURST_INCR;
    assign wpermit   = {BW_STRB{wenable}};

    assign start_accept    = (state == ST_IDLE) && start;
    assign beat_fire       = (state == ST_DATA) && sxrvalid && sxrready;
    assign beat_is_last    = (beat_cnt_q == beats_q - 9'd1);
    assign addr_step       = BW_ADDR'({beats_q, 2'b00});
    assign remaining_after = remaining_q - BW_INDEX'(beats_q);

    requant_axi_burst_calc #(
        .BW_INDEX      (BW_INDEX),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_burst_calc (
        .remaining   (remaining_q),
        .word_offset (addr_q[11:2]),
        .beats       (calc_beats)
    );

    // Transfer sequencer: latches the request, sizes and issues each burst,
    // forwards returned beats to the buffer and reports completion.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            wptr_q      <= '0;
            beats_q     <= '0;
            beat_cnt_q  <= '0;
            draining_q  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            sxaraddr    <= '0;
            sxarlen     <= '0;
            sxarvalid   <= 1'b0;
            sxrready    <= 1'b0;
            windex      <= '0;
            wenable     <= 1'b0;
            wdata       <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge value of every register regardless of statement order.
            done    <= 1'b0;
            wenable <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        if (num_words == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr_q      <= src_addr & ~BW_ADDR'(3);
                            remaining_q <= num_words;
                            wptr_q      <= dst_index;
                            busy        <= 1'b1;
                            state       <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    beats_q   <= calc_beats;
                    sxaraddr  <= addr_q;
                    sxarlen   <= 8'(calc_beats - 9'd1);
                    sxarvalid <= 1'b1;
                    state     <= ST_ADDR;
                end
                ST_ADDR: begin
                    if (sxarready) begin
                        sxarvalid  <= 1'b0;
                        sxrready   <= 1'b1;
                        beat_cnt_q <= '0;
                        draining_q <= 1'b0;
                        state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_fire) begin
                        if (sxrresp != RESP_OKAY) error <= 1'b1;
                        if (!draining_q) begin
                            wenable    <= 1'b1;
                            windex     <= wptr_q;
                            wdata      <= sxrdata;
                            wptr_q     <= wptr_q + 1'b1;
                            beat_cnt_q <= beat_cnt_q + 9'd1;
                            if (beat_is_last) begin
                                addr_q      <= addr_q + addr_step;
                                remaining_q <= remaining_after;
                                if (sxrlast) begin
                                    sxrready <= 1'b0;
                                    state    <= (remaining_after != '0) ? ST_CALC : ST_FLUSH;
                                end else begin
                                    // Slave overruns the burst: discard until it flags last.
                                    error      <= 1'b1;
                                    draining_q <= 1'b1;
                                end
                            end else if (sxrlast) begin
                                error <= 1'b1;
                            end
                        end else if (sxrlast) begin
                            // Address and count were already advanced at the expected last beat.
                            sxrready <= 1'b0;
                            state    <= (remaining_q != '0) ? ST_CALC : ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef REQUANT_AXI_FETCH_PERF_EN
    logic [31:0] perf_q;

    // Busy-cycle counter: restarts on each accepted start, holds after done.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            perf_q <= '0;
        end else if (start_accept) begin
            perf_q <= '0;
        end else if (busy) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    logic unused_perf;

    assign unused_perf = start_accept;
    assign perf_cycles = '0;
`endif

endmodule

// File: doc/requant_axi_fetch_master.md
Name: requant_axi_fetch_master

Overview:
- AXI4 read initiator that bulk-loads requantizer input data from external memory into a local simple-dual-port BRAM write port.
- Software programs source address, word count and destination index, then pulses start.
- The block issues INCR read bursts, writes each returned beat into the buffer, and raises done.
- Sits beside the requant engine's AXI slave so input data no longer needs CPU word-by-word writes.

Parameters:
- BW_ADDR, 32, AXI address width.
- BW_DATA, 32, AXI data and buffer word width; must be 32 in this revision.
- BW_AXI_TID, 4, AXI transaction ID width.
- AXI_TID, 0, constant ID driven on every AR request.
- BW_INDEX, 13, buffer word-index width; also width of num_words.
- MAX_BURST_LEN, 16, max beats per burst (1..256).

Ports:
- clk  in  1  clock
- rstnn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request pulse
- src_addr  in  BW_ADDR  external byte address; bits[1:0] ignored (treated as 0)
- num_words  in  BW_INDEX  words to fetch
- dst_index  in  BW_INDEX  first buffer index
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- error  out  1  sticky; set on bad RRESP or RLAST mismatch, cleared on accepted start
- sxarid  out  BW_AXI_TID  = AXI_TID
- sxaraddr  out  BW_ADDR  burst address
- sxarlen  out  8  beats-1
- sxarsize  out  3  constant 3'b010
- sxarburst  out  2  constant INCR (2'b01)
- sxarvalid  out  1  AR valid
- sxarready  in  1  AR ready
- sxrid  in  BW_AXI_TID  ignored
- sxrdata  in  BW_DATA  read data
- sxrresp  in  2  read response
- sxrlast  in  1  last beat
- sxrvalid  in  1  R valid
- sxrready  out  1  R ready
- windex  out  BW_INDEX  buffer write index
- wenable  out  1  buffer write strobe
- wpermit  out  BW_DATA/8  byte enables, all ones when wenable
- wdata  out  BW_DATA  buffer write data
- perf_cycles  out  32  busy-cycle count (see Optional Feature)

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0; error 0.
- FSM states: IDLE, CALC, ADDR, DATA, FLUSH.
- IDLE:
  - start with num_words=0 -> done=1 the next cycle; no AXI traffic; busy stays 0.
  - start with num_words>0 -> latch address/count/index, busy=1, clear error, go to CALC.
- CALC (1 cycle): beats = min(remaining, MAX_BURST_LEN, (4096 - addr[11:0])/4). Bursts never cross a 4KB boundary. Go to ADDR.
- ADDR: sxarvalid=1 with address/len held stable until sxarready; on handshake go to DATA.
- DATA:
  - sxrready=1 (the buffer never stalls).
  - Each accepted beat registers wenable=1, windex, wdata one cycle later; windex increments by 1 per beat and wraps mod 2^BW_INDEX.
  - RRESP != OKAY -> error=1; the transfer continues.
  - sxrlast on a beat other than the expected last beat, or missing on the expected last beat -> error=1; the burst ends at the expected beat count. Late beats are still accepted and discarded until sxrlast.
  - After the burst ends: address advances by beats*4 and remaining decrements. Go to CALC if remaining>0, else FLUSH.
- FLUSH (1 cycle): final buffer write completes; done=1, busy=0; go to IDLE.
- Outstanding bursts: exactly one at a time; sxarvalid is never asserted while in DATA.
- start while busy: ignored.
- Reset mid-transfer: immediate return to IDLE, outputs cleared. The AXI interconnect must be reset together with the block.

Optional Feature:
- Macro: REQUANT_AXI_FETCH_PERF_EN.
- Defined: perf_cycles counts cycles with busy=1; it clears on accepted start and holds its value after done.
- Undefined: perf_cycles tied to 0 and no counter logic is synthesized.

Decomposition:
- Shared package holds: AXI constants (ABURST_INCR, ASIZE_4B, RESP_OKAY, 4KB boundary), the FSM state encoding, and the MAX_BURST_LEN bound check.
- One natural sub-module: requant_axi_burst_calc, a combinational min/boundary length calculator (remaining, addr -> beats).

Test Plan:
- num_words=10, src_addr=0x8000_0000, dst_index=0, MAX_BURST_LEN=16 -> one AR with len=9; buffer words 0..9 match memory; done 1 cycle after last write; error=0.
- num_words=40, src_addr=0x8000_0FF0 -> ARs of len 3 (4 beats to boundary), then len 15, 15, 3; addresses 0x..0FF0, 0x..1000, 0x..1040, 0x..1080.
- num_words=0 -> done the next cycle, sxarvalid never asserted.
- Slave returns SLVERR on beat 3 of 8 -> all 8 words written, error=1 at done; next start clears error.
- Random sxarready/sxrvalid backpressure with start pulsed mid-transfer -> second start ignored; data is bit-exact; with REQUANT_AXI_FETCH_PERF_EN, perf_cycles equals the number of busy cycles.
- dst_index=8190, num_words=4, BW_INDEX=13 -> writes land at indices 8190, 8191, 0, 1.
